// File: rtl/panxi_spsram_arb.sv
// Two-master round-robin arbiter and sequencer in front of one single-port SRAM.
// Each master owns a response slot that holds its read data while the master stalls.
module panxi_spsram_arb #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  ACLK,
    input  logic                  ARST,

    input  logic                  M0_REQ_VALID,
    output logic                  M0_REQ_READY,
    input  logic [ADDR_WIDTH-1:0] M0_REQ_ADDR,
    input  logic                  M0_REQ_WRITE,
    input  logic [DATA_WIDTH-1:0] M0_REQ_WDATA,
    input  logic [STRB_WIDTH-1:0] M0_REQ_WSTRB,
    output logic                  M0_RSP_VALID,
    input  logic                  M0_RSP_READY,
    output logic [DATA_WIDTH-1:0] M0_RSP_RDATA,

    input  logic                  M1_REQ_VALID,
    output logic                  M1_REQ_READY,
    input  logic [ADDR_WIDTH-1:0] M1_REQ_ADDR,
    input  logic                  M1_REQ_WRITE,
    input  logic [DATA_WIDTH-1:0] M1_REQ_WDATA,
    input  logic [STRB_WIDTH-1:0] M1_REQ_WSTRB,
    output logic                  M1_RSP_VALID,
    input  logic                  M1_RSP_READY,
    output logic [DATA_WIDTH-1:0] M1_RSP_RDATA,

    output logic                  CEN,
    output logic                  GWEN,
    output logic [DATA_WIDTH-1:0] AWEN,
    output logic [ADDR_WIDTH-1:0] AADDR,
    output logic [DATA_WIDTH-1:0] ADATA_XI,
    input  logic [DATA_WIDTH-1:0] ADATA_XO
);

    typedef enum logic [1:0] {
        SlotEmpty = 2'b00,
        SlotFresh = 2'b01,
        SlotHeld  = 2'b10
    } slot_e;

    logic [1:0]            req_valid;
    logic [1:0]            req_write;
    logic [1:0]            rsp_ready;
    logic [1:0]            slot_empty;
    logic [1:0]            rsp_valid;
    logic [1:0]            eligible;
    logic [1:0]            grant;
    logic [ADDR_WIDTH-1:0] req_addr  [2];
    logic [DATA_WIDTH-1:0] req_wdata [2];
    logic [STRB_WIDTH-1:0] req_wstrb [2];
    logic [DATA_WIDTH-1:0] rsp_rdata [2];
    logic                  last_grant_q;
    logic                  last_grant_d;
    logic                  sel;

    assign req_valid    = {M1_REQ_VALID, M0_REQ_VALID};
    assign req_write    = {M1_REQ_WRITE, M0_REQ_WRITE};
    assign rsp_ready    = {M1_RSP_READY, M0_RSP_READY};
    assign req_addr[0]  = M0_REQ_ADDR;
    assign req_addr[1]  = M1_REQ_ADDR;
    assign req_wdata[0] = M0_REQ_WDATA;
    assign req_wdata[1] = M1_REQ_WDATA;
    assign req_wstrb[0] = M0_REQ_WSTRB;
    assign req_wstrb[1] = M1_REQ_WSTRB;

    // Eligibility uses only slot state and RSP_READY, never ADATA_XO.
    always_comb begin
        eligible = req_valid & ~{2{ARST}} & (slot_empty | rsp_ready);
        grant    = eligible;
        if (&eligible) begin
            grant = last_grant_q ? 2'b01 : 2'b10;
        end
        last_grant_d = last_grant_q;
        if (|grant) begin
            last_grant_d = grant[1];
        end
    end

    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    assign sel = grant[1];

    always_comb begin
        CEN      = 1'b1;
        GWEN     = 1'b1;
        AWEN     = '1;
        AADDR    = '0;
        ADATA_XI = '0;
        if (|grant) begin
            CEN      = 1'b0;
            AADDR    = req_addr[sel];
            ADATA_XI = req_wdata[sel];
            if (req_write[sel]) begin
                GWEN = 1'b0;
                for (int b = 0; b < STRB_WIDTH; b++) begin
                    AWEN[8*b +: 8] = {8{~req_wstrb[sel][b]}};
                end
            end
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_slot
        slot_e                 slot_q;
        slot_e                 slot_d;
        logic                  wr_q;
        logic                  wr_d;
        logic [DATA_WIDTH-1:0] hold_q;
        logic [DATA_WIDTH-1:0] hold_d;
        logic [DATA_WIDTH-1:0] rdata;

        always_comb begin
            slot_d = slot_q;
            wr_d   = wr_q;
            hold_d = hold_q;
            rdata  = '0;
            case (slot_q)
                SlotFresh: rdata = wr_q ? '0 : ADATA_XO;
                SlotHeld:  rdata = hold_q;
                default:   rdata = '0;
            endcase
            if (grant[i]) begin
                slot_d = SlotFresh;
                wr_d   = req_write[i];
            end else if (slot_q != SlotEmpty) begin
                if (rsp_ready[i]) begin
                    slot_d = SlotEmpty;
                end else begin
                    // Freeze the shared SRAM output before another access overwrites it.
                    slot_d = SlotHeld;
                    hold_d = rdata;
                end
            end
        end

        always_ff @(posedge ACLK or posedge ARST) begin
            if (ARST) begin
                slot_q <= SlotEmpty;
                wr_q   <= 1'b0;
                hold_q <= '0;
            end else begin
                slot_q <= slot_d;
                wr_q   <= wr_d;
                hold_q <= hold_d;
            end
        end

        assign slot_empty[i] = (slot_q == SlotEmpty);
        assign rsp_valid[i]  = ~slot_empty[i];
        assign rsp_rdata[i]  = rdata;
    end

    assign M0_REQ_READY = grant[0];
    assign M1_REQ_READY = grant[1];
    assign M0_RSP_VALID = rsp_valid[0];
    assign M1_RSP_VALID = rsp_valid[1];
    assign M0_RSP_RDATA = rsp_rdata[0];
    assign M1_RSP_RDATA = rsp_rdata[1];

endmodule
